// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: data width, opcode encodings
// and FSM state constants.
package alu_pkg;

    localparam int DATA_W = 8;

    // Opcode encodings (SELECT)
    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_ROR = 3'b111;

    // FSM state type and encodings
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIN  = 2'd2;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational evaluation of the single-cycle opcodes
// (FWD/ADD/AND/OR). Iterative opcodes evaluate to zero here; the
// control unit's branch-compare path also reuses this block.
module alu_comb
    import alu_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    // Select the single-cycle result; carry out of ADD is dropped
    always_comb begin
        y = '0;
        case (op)
            ALU_FWD: y = b;
            ALU_ADD: y = a + b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential 8-bit ALU with START/BUSY/DONE handshake.
// Handshake: START is sampled only while IDLE (BUSY=0); a request seen in
// any other state is dropped. DONE pulses for one cycle in FIN, and
// RESULT/ZERO are valid from that cycle until the next completion.
// Build option: define ALU_MUL_EN to include the iterative shift-add
// multiplier; otherwise opcode 100 completes in one cycle with RESULT=0.
module alu_seq
    import alu_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [2:0]        SELECT,
    input  logic [DATA_W-1:0] DATA1,
    input  logic [DATA_W-1:0] DATA2,
    output logic [DATA_W-1:0] RESULT,
    output logic              ZERO,
    output logic              BUSY,
    output logic              DONE
);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] work_q, work_d;     // shift operand or multiplicand
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] step;               // working value after this RUN step
    logic [DATA_W-1:0] comb_y;
`ifdef ALU_MUL_EN
    logic [DATA_W-1:0] mplr_q, mplr_d;     // multiplier, consumed LSB first
    logic [DATA_W-1:0] acc_q, acc_d;
`endif

    alu_comb u_alu_comb (
        .op (SELECT),
        .a  (DATA1),
        .b  (DATA2),
        .y  (comb_y)
    );

    // Next-state logic: capture in IDLE, iterate in RUN, pulse DONE in FIN
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        result_d = result_q;
        zero_d   = zero_q;
        step     = work_q;
`ifdef ALU_MUL_EN
        mplr_d   = mplr_q;
        acc_d    = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    op_d = SELECT;
                    if (!SELECT[2]) begin
                        result_d = comb_y;
                        zero_d   = (comb_y == '0);
                        state_d  = ST_FIN;
                    end else if (SELECT == ALU_MUL) begin
`ifdef ALU_MUL_EN
                        cnt_d   = 4'd8;
                        acc_d   = '0;
                        work_d  = DATA1;
                        mplr_d  = DATA2;
                        state_d = ST_RUN;
`else
                        result_d = '0;
                        zero_d   = 1'b1;
                        state_d  = ST_FIN;
`endif
                    end else if (DATA2[2:0] == 3'd0) begin
                        // Shift by zero passes A straight through
                        result_d = DATA1;
                        zero_d   = (DATA1 == '0);
                        state_d  = ST_FIN;
                    end else begin
                        cnt_d   = {1'b0, DATA2[2:0]};
                        work_d  = DATA1;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                case (op_q)
                    ALU_SLL: step = {work_q[DATA_W-2:0], 1'b0};
                    ALU_SRL: step = {1'b0, work_q[DATA_W-1:1]};
                    ALU_ROR: step = {work_q[0], work_q[DATA_W-1:1]};
`ifdef ALU_MUL_EN
                    ALU_MUL: step = mplr_q[0] ? (acc_q + work_q) : acc_q;
`endif
                    default: step = work_q;
                endcase
`ifdef ALU_MUL_EN
                if (op_q == ALU_MUL) begin
                    acc_d  = step;
                    work_d = {work_q[DATA_W-2:0], 1'b0};
                    mplr_d = {1'b0, mplr_q[DATA_W-1:1]};
                end else begin
                    work_d = step;
                end
`else
                work_d = step;
`endif
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    result_d = step;
                    zero_d   = (step == '0);
                    state_d  = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            op_q     <= ALU_FWD;
            cnt_q    <= 4'd0;
            work_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
`ifdef ALU_MUL_EN
            mplr_q   <= '0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef ALU_MUL_EN
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign RESULT = result_q;
    assign ZERO   = zero_q;
    assign BUSY   = (state_q != ST_IDLE);
    assign DONE   = (state_q == ST_FIN);

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential 8-bit ALU sitting directly downstream of the register file: it consumes the two register-read operands (OUT1, OUT2) and produces a result for write-back into the register file. Single-cycle logic ops complete in one cycle. Multiply and variable shifts/rotates iterate one step per cycle under a START/BUSY/DONE handshake, so the control unit stalls instead of widening the critical path.

## Interface
- No parameters (data width fixed at 8, opcode width fixed at 3).
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- SELECT  input  3  opcode, captured with START.
- DATA1  input  8  operand A (register-file OUT1), captured with START.
- DATA2  input  8  operand B / shift amount (register-file OUT2), captured with START.
- RESULT  output  8  registered result; holds until the next completion.
- ZERO  output  1  registered; 1 when RESULT == 0x00.
- BUSY  output  1  1 whenever state != IDLE.
- DONE  output  1  one-cycle pulse; RESULT/ZERO valid from this cycle.

## Operation
- Opcodes:
  - 000 FWD: RESULT = B.
  - 001 ADD: A+B mod 256, carry dropped.
  - 010 AND.
  - 011 OR.
  - 100 MUL: low 8 bits of A*B.
  - 101 SLL: A << B[2:0].
  - 110 SRL: A >> B[2:0], zero fill.
  - 111 ROR: A rotated right by B[2:0].
  - B[7:3] is ignored for shift opcodes.
- FSM states: IDLE, RUN, FIN.
- IDLE, START=1:
  - Capture SELECT, DATA1, DATA2.
  - Opcodes 000–011: compute, load RESULT/ZERO, go to FIN.
  - MUL: load counter=8, accumulator=0, go to RUN.
  - Shifts with B[2:0]=n>0: counter=n, go to RUN.
  - Shifts with n=0: RESULT=A, go to FIN.
- RUN, each edge:
  - MUL: one shift-add step (if multiplier LSB, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1).
  - Shifts: shift/rotate the working register by 1.
  - Decrement counter. On the edge where counter reaches 0, load RESULT/ZERO from the working register and go to FIN.
- FIN: DONE=1 for exactly one cycle, then IDLE.
- START while BUSY=1 is ignored: not queued, no error.
- RESULT and ZERO never change except on entry to FIN or on reset. Intermediate values are never visible.
- Operand inputs may change freely after the capture edge.

## Timing
- Reset values: RESULT=0x00, ZERO=1, BUSY=0, DONE=0, state=IDLE, counter=0.
- Reset asserted mid-operation aborts immediately. No DONE is produced and RESULT returns to 0x00.
- Cycle numbering: the START capture edge is edge 0.
- Single-cycle ops and shift-by-0: FIN after edge 0; DONE high in cycle 1; BUSY high in cycle 1 only.
- Shift by n (1–7): RUN for n cycles; DONE in cycle n+1.
- MUL: RUN for 8 cycles; DONE in cycle 9.
- Back-to-back: a new START may be presented in the cycle after DONE (IDLE). The earliest accepted START is the edge ending that cycle. Throughput for single-cycle ops is one op per 2 cycles.
- START and reset deassertion on the same edge: reset wins and START is dropped.

## Configuration
- ALU_MUL_EN defined:
  - MUL opcode is implemented as above, with an 8-cycle latency.
- ALU_MUL_EN undefined:
  - The multiplier datapath is removed.
  - Opcode 100 becomes single-cycle, with RESULT=0x00, ZERO=1 and DONE in cycle 1.
  - All other opcodes are unchanged.

## Structure
- Shared package alu_pkg holds:
  - Opcode localparams (ALU_FWD … ALU_ROR).
  - FSM state typedef (IDLE/RUN/FIN).
  - Data width constant 8.
- One sub-module, alu_comb: purely combinational FWD/ADD/AND/OR evaluation, reused by the control unit's branch-compare path.
- Top module alu_seq holds the FSM, counter, working registers and the multiply/shift iteration.

## Test plan
- Reset mid-MUL: RESET pulsed at cycle 4 of MUL 0x0F*0x11 -> RESULT=0x00, ZERO=1, BUSY=0, and no DONE pulse ever appears.
- ADD 0xF0+0x20 -> DONE in cycle 1, RESULT=0x10, ZERO=0; then ADD 0x80+0x80 -> RESULT=0x00, ZERO=1.
- MUL 0x0D*0x0B (ALU_MUL_EN) -> BUSY for cycles 1–9, DONE in cycle 9, RESULT=0x8F. MUL 0x10*0x10 -> RESULT=0x00, ZERO=1.
- Shifts:
  - SLL A=0x81, B=0xF9 -> amount 1, DONE in cycle 2, RESULT=0x02.
  - ROR A=0x01, B=0x03 -> DONE in cycle 4, RESULT=0x20.
  - SRL amount 0 -> DONE in cycle 1, RESULT=A.
- START held high throughout a 5-cycle SRL with changing DATA1/SELECT -> only the first request executes; RESULT reflects the captured operands; the next op starts on the first edge in IDLE.
- Build without ALU_MUL_EN: MUL 0x03*0x05 -> DONE in cycle 1, RESULT=0x00, ZERO=1.
